// File: rtl/successive_approximation_control_if.sv
// Analog front-end / consumer bundle for the SAR controller.
// master: the controller side; slave: comparator model and conversion consumer.
interface successive_approximation_control_if #(
    parameter int WIDTH = 16
);
    logic             go;
    logic             cmp;
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] result;
    logic             valid;
    logic             sample;

    modport master (
        input  go,
        input  cmp,
        output value,
        output result,
        output valid,
        output sample
    );

    modport slave (
        output go,
        output cmp,
        input  value,
        input  result,
        input  valid,
        input  sample
    );
endinterface

// File: rtl/successive_approximation_control.sv
// Successive-approximation ADC controller: S/H strobe, then one bit per clock MSB first.
// All outputs come straight from registers.
module successive_approximation_control #(
    parameter int WIDTH         = 16,
    parameter int SAMPLE_CYCLES = 1
) (
    input logic clk,
    input logic reset,
    successive_approximation_control_if.master bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] value_r, value_n;
    logic [WIDTH-1:0] result_r, result_n;
    logic             valid_r, valid_n;
    logic             sample_r, sample_n;
    logic [IW-1:0]    idx, idx_n;
    logic [CW-1:0]    scnt, scnt_n;
    logic [WIDTH-1:0] trial;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            value_r  <= '0;
            result_r <= '0;
            valid_r  <= 1'b0;
            sample_r <= 1'b0;
            idx      <= IW'(WIDTH - 1);
            scnt     <= '0;
        end else begin
            state    <= state_n;
            value_r  <= value_n;
            result_r <= result_n;
            valid_r  <= valid_n;
            sample_r <= sample_n;
            idx      <= idx_n;
            scnt     <= scnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        value_n  = value_r;
        result_n = result_r;
        valid_n  = valid_r;
        sample_n = sample_r;
        idx_n    = idx;
        scnt_n   = scnt;
        trial    = value_r;
        case (state)
            IDLE, DONE: begin
                if (bus.go) begin
                    state_n  = SAMPLE;
                    sample_n = 1'b1;
                    scnt_n   = CW'(SAMPLE_CYCLES - 1);
                end
            end
            SAMPLE: begin
                if (scnt == '0) begin
                    sample_n            = 1'b0;
                    value_n             = '0;
                    value_n[WIDTH-1]    = 1'b1;
                    idx_n               = IW'(WIDTH - 1);
                    valid_n             = 1'b0;
                    state_n             = CONVERT;
                end else begin
                    scnt_n = scnt - 1'b1;
                end
            end
            CONVERT: begin
                // cmp judges the trial bit presented during the cycle just ending
                if (bus.cmp)
                    trial[idx] = 1'b0;
                if (idx != '0) begin
                    trial[idx - 1'b1] = 1'b1;
                    idx_n             = idx - 1'b1;
                end else begin
                    result_n = trial;
                    valid_n  = 1'b1;
                    state_n  = DONE;
                end
                value_n = trial;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.value  = value_r;
    assign bus.result = result_r;
    assign bus.valid  = valid_r;
    assign bus.sample = sample_r;
endmodule

// File: tb/tb_successive_approximation_control.sv
// Directed bench for the SAR controller with an ideal comparator against a
// fixed-point analog input (hundredths of an LSB).
module tb_successive_approximation_control;
    logic        clk;
    logic        reset;
    logic [31:0] ain_c;
    int          total;
    int          bad;

    successive_approximation_control_if #(.WIDTH(16)) bus ();

    successive_approximation_control #(
        .WIDTH(16),
        .SAMPLE_CYCLES(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // cmp=1 when the analog input is below the trial code
    assign bus.cmp = (ain_c < (32'(bus.value) * 32'd100));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] v, input logic [15:0] r,
                             input logic vl, input logic s);
        check({tag, ".value"},  32'(bus.value),  32'(v));
        check({tag, ".result"}, 32'(bus.result), 32'(r));
        check({tag, ".valid"},  32'(bus.valid),  32'(vl));
        check({tag, ".sample"}, 32'(bus.sample), 32'(s));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total  = 0;
        bad    = 0;
        reset  = 1'b0;
        bus.go = 1'b1;
        ain_c  = 32'd1103742;

        // reset held with go high: everything stays cleared
        for (int i = 0; i < 10; i++) begin
            step();
            check_all("reset_hold", 16'h0000, 16'h0000, 1'b0, 1'b0);
        end

        // release with go=1: next edge enters SAMPLE; go then pulses low
        reset = 1'b1;
        step();
        check("nom.sample_hi", 32'(bus.sample), 32'd1);
        bus.go = 1'b0;
        step();
        check_all("nom.e1", 16'h8000, 16'h0000, 1'b0, 1'b0);
        step();
        check("nom.e2.value", 32'(bus.value), 32'h4000);
        step();
        check("nom.e3.value", 32'(bus.value), 32'h2000);
        step();
        check("nom.e4.value", 32'(bus.value), 32'h3000);
        for (int e = 5; e < 17; e++) step();
        check("nom.e16.valid", 32'(bus.valid), 32'd0);
        step();
        check_all("nom.e17", 16'h2B1D, 16'h2B1D, 1'b1, 1'b0);

        // DONE holds without go
        for (int i = 0; i < 3; i++) step();
        check_all("done_hold", 16'h2B1D, 16'h2B1D, 1'b1, 1'b0);

        // full scale high
        ain_c  = 32'd6553550;
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        check("fs.sample_valid_kept", 32'(bus.valid), 32'd1);
        check("fs.sample_hi", 32'(bus.sample), 32'd1);
        step();
        check("fs.convert_valid_drop", 32'(bus.valid), 32'd0);
        check("fs.convert_result_kept", 32'(bus.result), 32'h2B1D);
        for (int e = 2; e <= 17; e++) step();
        check_all("fs.ffff", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);

        // full scale low
        ain_c  = 32'd0;
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        for (int e = 1; e <= 17; e++) step();
        check_all("zs.0000", 16'h0000, 16'h0000, 1'b1, 1'b0);

        // go held high: one conversion every 18 edges
        ain_c  = 32'd1103742;
        bus.go = 1'b1;
        step();
        for (int c = 0; c < 3; c++) begin
            step();
            check("cont.valid_drop", 32'(bus.valid), 32'd0);
            for (int e = 2; e < 17; e++) step();
            check("cont.valid_pre", 32'(bus.valid), 32'd0);
            step();
            check_all("cont.done", 16'h2B1D, 16'h2B1D, 1'b1, 1'b0);
            step();
            check("cont.resample", 32'(bus.sample), 32'd1);
            check("cont.resample_valid", 32'(bus.valid), 32'd1);
            check("cont.resample_result", 32'(bus.result), 32'h2B1D);
        end

        // go dropped while in SAMPLE/CONVERT: conversion still completes
        bus.go = 1'b0;
        step();
        check("glitch.e1.value", 32'(bus.value), 32'h8000);
        for (int e = 2; e <= 17; e++) step();
        check_all("glitch.done", 16'h2B1D, 16'h2B1D, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step();
        check_all("glitch.hold", 16'h2B1D, 16'h2B1D, 1'b1, 1'b0);

        // reset during bit 7 of CONVERT clears without a clock edge
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        step();
        for (int e = 2; e <= 9; e++) step();
        check("midrst.busy", 32'(bus.valid), 32'd0);
        reset = 1'b0;
        #1;
        check_all("midrst.async", 16'h0000, 16'h0000, 1'b0, 1'b0);
        step();
        step();
        check_all("midrst.held", 16'h0000, 16'h0000, 1'b0, 1'b0);
        bus.go = 1'b1;
        reset  = 1'b1;
        step();
        bus.go = 1'b0;
        check("midrst.sample", 32'(bus.sample), 32'd1);
        for (int e = 1; e <= 17; e++) step();
        check_all("midrst.fresh", 16'h2B1D, 16'h2B1D, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
